// File: rtl/cla8_pipe_adder.sv
// cla8_pipe_adder: two-stage pipelined 8-bit carry-lookahead add/subtract unit.
//
// Stage 1 registers bit propagate/generate terms, the effective carry-in and the
// operand sign bits. Between the stages, two nibble lookahead groups built from
// NAND-NAND (AND-OR) terms produce every carry. Stage 2 registers the sum and the
// flags and holds them until the consumer accepts.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  upstream handshake; in_ready is combinational from out_ready
//   in_a, in_b           operands
//   in_cin               carry-in, ignored when in_sub = 1
//   in_sub               1 = A - B (B inverted, carry-in forced to 1)
//   out_valid/out_ready  downstream handshake
//   out_sum              result, modulo 256
//   out_cout             carry-out; for subtract, 1 means no borrow
//   out_ovf              signed overflow
//   out_zero, out_neg    out_sum == 0, out_sum[7]
//   op_count             completed output transfers, saturating
//
// Only WIDTH = 8 is supported: the lookahead is two fixed nibble groups.

module cla8_pipe_adder #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_cin,
  input  logic               in_sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_sum,
  output logic               out_cout,
  output logic               out_ovf,
  output logic               out_zero,
  output logic               out_neg,
  output logic [COUNT_W-1:0] op_count
);

  // Lookahead result of one nibble: group generate/propagate plus the three
  // carries internal to the nibble (c1..c3 relative to its carry-in).
  typedef struct packed {
    logic       gg;
    logic       gp;
    logic [2:0] c;
  } nib_la_t;

  // Cell-level primitives; the lookahead is expressed only in these gates.
  function automatic logic nand2(input logic a, input logic b);
    return ~(a & b);
  endfunction

  function automatic logic nand3(input logic a, input logic b, input logic c);
    return ~(a & b & c);
  endfunction

  function automatic logic nand5(input logic a, input logic b, input logic c,
                                 input logic d, input logic e);
    return ~(a & b & c & d & e);
  endfunction

  // Four-bit lookahead. Each carry is an AND-OR sum realised as NAND-NAND; a
  // single-literal term enters the outer NAND inverted (nand2(x, x) = ~x), and
  // unused NAND5 inputs are tied high.
  function automatic nib_la_t nib_lookahead(input logic [3:0] p, input logic [3:0] g,
                                            input logic cin);
    nib_la_t r;
    logic    gp_n;
    // c1 = g0 | p0 cin
    r.c[0] = nand2(nand2(g[0], g[0]), nand2(p[0], cin));
    // c2 = g1 | p1 g0 | p1 p0 cin
    r.c[1] = nand3(nand2(g[1], g[1]), nand2(p[1], g[0]), nand3(p[1], p[0], cin));
    // c3 = g2 | p2 g1 | p2 p1 g0 | p2 p1 p0 cin
    r.c[2] = nand5(nand2(g[2], g[2]), nand2(p[2], g[1]), nand3(p[2], p[1], g[0]),
                   nand5(p[2], p[1], p[0], cin, 1'b1), 1'b1);
    // GG = g3 | p3 g2 | p3 p2 g1 | p3 p2 p1 g0
    r.gg   = nand5(nand2(g[3], g[3]), nand2(p[3], g[2]), nand3(p[3], p[2], g[1]),
                   nand5(p[3], p[2], p[1], g[0], 1'b1), 1'b1);
    // GP = p3 p2 p1 p0
    gp_n   = nand5(p[3], p[2], p[1], p[0], 1'b1);
    r.gp   = nand2(gp_n, gp_n);
    return r;
  endfunction

  // Carry out of a nibble: GG | GP cin.
  function automatic logic group_carry(input logic gg, input logic gp, input logic cin);
    return nand2(nand2(gg, gg), nand2(gp, cin));
  endfunction

  // Handshake / advance.
  logic s1_valid_q, s2_valid_q;
  logic s1_adv, s2_adv, in_xfer, out_xfer;

  always_comb begin
    s2_adv   = ~s2_valid_q | out_ready;
    s1_adv   = ~s1_valid_q | s2_adv;
    in_xfer  = in_valid & s1_adv;
    out_xfer = s2_valid_q & out_ready;
  end

  assign in_ready = s1_adv;

  // Stage 1: operand conditioning.
  logic [7:0] s1_p_q, s1_g_q;
  logic       s1_c0_q, s1_a7_q, s1_b7_q;
  logic [7:0] b_eff;
  logic       c0_eff;

  always_comb begin
    b_eff  = in_sub ? ~in_b : in_b;
    c0_eff = in_sub ? 1'b1 : in_cin;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_p_q     <= '0;
      s1_g_q     <= '0;
      s1_c0_q    <= 1'b0;
      s1_a7_q    <= 1'b0;
      s1_b7_q    <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= in_xfer;
      if (in_xfer) begin
        s1_p_q  <= in_a ^ b_eff;
        s1_g_q  <= in_a & b_eff;
        s1_c0_q <= c0_eff;
        s1_a7_q <= in_a[7];
        s1_b7_q <= b_eff[7];
      end
    end
  end

  // Lookahead between the stages. The high nibble takes c4 from the low group
  // signals, so no carry ripples across the nibble boundary.
  nib_la_t    la_lo, la_hi;
  logic [8:0] carry;
  logic [7:0] sum_d;
  logic       cout_d, ovf_d, zero_d, neg_d;

  always_comb begin
    la_lo    = nib_lookahead(s1_p_q[3:0], s1_g_q[3:0], s1_c0_q);
    carry[0] = s1_c0_q;
    carry[3:1] = la_lo.c;
    carry[4] = group_carry(la_lo.gg, la_lo.gp, s1_c0_q);
    la_hi    = nib_lookahead(s1_p_q[7:4], s1_g_q[7:4], carry[4]);
    carry[7:5] = la_hi.c;
    carry[8] = group_carry(la_hi.gg, la_hi.gp, carry[4]);

    sum_d[6:0] = s1_p_q[6:0] ^ carry[6:0];
    // The MSB uses the registered sign bits (p7 = a7 ^ b'7).
    sum_d[7]   = s1_a7_q ^ s1_b7_q ^ carry[7];
    cout_d     = carry[8];
    ovf_d      = carry[8] ^ carry[7];
    zero_d     = (sum_d == 8'h00);
    neg_d      = sum_d[7];
  end

  // Stage 2: result register, held while the consumer stalls.
  logic [7:0] s2_sum_q;
  logic       s2_cout_q, s2_ovf_q, s2_zero_q, s2_neg_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
      s2_cout_q  <= 1'b0;
      s2_ovf_q   <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_neg_q   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      s2_sum_q   <= sum_d;
      s2_cout_q  <= cout_d;
      s2_ovf_q   <= ovf_d;
      s2_zero_q  <= zero_d;
      s2_neg_q   <= neg_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_sum   = s2_sum_q;
  assign out_cout  = s2_cout_q;
  assign out_ovf   = s2_ovf_q;
  assign out_zero  = s2_zero_q;
  assign out_neg   = s2_neg_q;

  // Completed-operation counter, sticks at all-ones.
  logic [COUNT_W-1:0] op_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_q <= '0;
    end else if (out_xfer && (op_count_q != '1)) begin
      op_count_q <= op_count_q + COUNT_W'(1);
    end
  end

  assign op_count = op_count_q;

endmodule

// File: tb/tb_cla8_pipe_adder.sv
module tb_cla8_pipe_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_a, in_b;
  logic       in_cin, in_sub;
  logic       out_ready;

  logic        in_ready, out_valid, out_cout, out_ovf, out_zero, out_neg;
  logic [7:0]  out_sum;
  logic [15:0] op_count;

  logic       in_ready_s, out_valid_s, out_cout_s, out_ovf_s, out_zero_s, out_neg_s;
  logic [7:0] out_sum_s;
  logic [3:0] op_count_s;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cla8_pipe_adder #(.WIDTH(8), .COUNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero),
    .out_neg(out_neg), .op_count(op_count)
  );

  cla8_pipe_adder #(.WIDTH(8), .COUNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_sum(out_sum_s),
    .out_cout(out_cout_s), .out_ovf(out_ovf_s), .out_zero(out_zero_s),
    .out_neg(out_neg_s), .op_count(op_count_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic sub);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t       vecs[10];
  logic [8:0] bp_exp[4];
  logic [7:0] bp_a[4];
  logic [7:0] bp_b[4];
  logic [11:0] exp_res;
  int         in_idx, out_idx;
  logic       saw_valid;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           a      b      cin   sub   sum    cout  ovf
    vecs[0] = '{8'h3C, 8'h45, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[4] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[5] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[6] = '{8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'h55, 8'h55, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[8] = '{8'h05, 8'h03, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0};
    vecs[9] = '{8'hC8, 8'h9C, 1'b0, 1'b0, 8'h64, 1'b1, 1'b1};

    bp_a[0] = 8'h01; bp_b[0] = 8'h01; bp_exp[0] = 9'h002;
    bp_a[1] = 8'h02; bp_b[1] = 8'h03; bp_exp[1] = 9'h005;
    bp_a[2] = 8'h10; bp_b[2] = 8'h20; bp_exp[2] = 9'h030;
    bp_a[3] = 8'hFF; bp_b[3] = 8'h01; bp_exp[3] = 9'h100;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset out_valid", out_valid, 0);
    chk("reset out_sum", out_sum, 0);
    chk("reset flags", {out_cout, out_ovf, out_zero, out_neg}, 0);
    chk("reset op_count", op_count, 0);
    chk("reset in_ready", in_ready, 1);

    // Single operations, no stall: result valid two edges after acceptance.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      chk("vec in_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk("vec latency valid low", out_valid, 0);
      tick();
      chk("vec out_valid", out_valid, 1);
      exp_res = {vecs[i].s, vecs[i].co, vecs[i].ov, (vecs[i].s == 8'h00), vecs[i].s[7]};
      chk($sformatf("vec%0d {sum,cout,ovf,zero,neg}", i),
          {out_sum, out_cout, out_ovf, out_zero, out_neg}, exp_res);
      tick();
    end
    chk("vec op_count", op_count, 10);
    chk("vec drained", out_valid, 0);

    // Backpressure: both stages fill, then the stall is released.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    drive(bp_a[0], bp_b[0], 1'b0, 1'b0);
    tick();
    drive(bp_a[1], bp_b[1], 1'b0, 1'b0);
    chk("bp in_ready second", in_ready, 1);
    tick();
    drive(bp_a[2], bp_b[2], 1'b0, 1'b0);
    chk("bp full in_ready", in_ready, 0);
    chk("bp full out_valid", out_valid, 1);
    chk("bp full out_sum", out_sum, 8'h02);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp hold out_sum", {out_cout, out_sum}, 9'h002);
      chk("bp hold in_ready", in_ready, 0);
      chk("bp hold out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp release in_ready", in_ready, 1);
    in_idx  = 2;
    out_idx = 0;
    for (int cyc = 0; cyc < 20 && out_idx < 4; cyc++) begin
      if (in_idx < 4) drive(bp_a[in_idx], bp_b[in_idx], 1'b0, 1'b0);
      else in_valid = 1'b0;
      #1;
      if (out_valid && out_ready) begin
        chk($sformatf("bp result%0d {cout,sum}", out_idx), {out_cout, out_sum},
            bp_exp[out_idx]);
        out_idx++;
      end
      if (in_valid && in_ready) in_idx++;
      tick();
    end
    in_valid = 1'b0;
    chk("bp results seen", out_idx, 4);
    chk("bp op_count", op_count, 4);
    chk("bp drained", out_valid, 0);

    // Reset with two operations in flight.
    drive(8'h33, 8'h11, 1'b0, 1'b0);
    tick();
    drive(8'h22, 8'h22, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst out_valid", out_valid, 0);
    chk("midrst op_count", op_count, 0);
    chk("midrst in_ready", in_ready, 1);
    saw_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (out_valid) saw_valid = 1'b1;
    end
    chk("midrst no stale result", saw_valid, 0);
    chk("midrst op_count after", op_count, 0);

    // Saturation: 20 completed ops; the 4-bit counter must stop at 15.
    for (int k = 0; k < 20; k++) begin
      drive(8'(k), 8'h01, 1'b0, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("sat op_count 4-bit", op_count_s, 15);
    chk("sat op_count 16-bit", op_count, 20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cla8_pipe_adder.md
Name: cla8_pipe_adder

Overview:
- 2-stage pipelined 8-bit carry-lookahead add/subtract unit with valid/ready handshakes on both sides.
- Consumes operands from the datapath register file.
- Stage 1 computes bit propagate/generate and the nibble-level lookahead carries. These are wide AND-OR terms up to 5 inputs, e.g. c4 = g3|p3g2|p3p2g1|p3p2p1g0|p3p2p1p0c0, implemented from the delay-annotated nand2/3/5 cells.
- Stage 2 forms sum and flags and holds the result for the downstream consumer.

Parameters:
- WIDTH, 8, operand width. Only 8 is supported; the lookahead is structured as 2 nibble groups.
- COUNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  stage 1 can accept this cycle.
- in_a  input  8  operand A.
- in_b  input  8  operand B.
- in_cin  input  1  carry-in; ignored when in_sub=1.
- in_sub  input  1  1 = A - B (B inverted, carry-in forced to 1).
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts.
- out_sum  output  8  result.
- out_cout  output  1  carry-out. For subtract, 1 means no borrow.
- out_ovf  output  1  signed overflow.
- out_zero  output  1  out_sum == 0.
- out_neg  output  1  out_sum[7].
- op_count  output  COUNT_W  number of completed output transfers, saturating.

Behaviour:
- Reset (sync, rst=1 at a rising edge): s1_valid=0, s2_valid=0, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, out_zero=0, out_neg=0, op_count=0. in_ready reads 1 from the first cycle after reset.
- Reset mid-operation discards all in-flight operations; no partial result appears.
- Transfer rules: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Stage 2 advance: s2_adv = !s2_valid | out_ready.
- Stage 1 advance: s1_adv = !s1_valid | s2_adv.
- in_ready = s1_adv. This is combinational from out_ready; there is no skid buffer.
- Stage 1 register: on input transfer, latch the following, then set s1_valid=1:
  - p = a ^ b'
  - g = a & b'
  - c0
  - a[7]
  - b'[7]
  - where b' = in_sub ? ~in_b : in_b and c0 = in_sub ? 1 : in_cin.
- Stage 1 when s1_adv and no input transfer: s1_valid=0.
- Stage 1 lookahead, computed from the stage-1 register (combinational between the two stages):
  - c1..c4 from the low-nibble lookahead on c0.
  - Group signals GP0 = p3p2p1p0 and GG0.
  - c5..c8 from the high-nibble lookahead using c4 = GG0 | GP0·c0. Carries do not ripple across the nibble boundary.
- Stage 2 register: on s2_adv, capture the following, with s2_valid <= s1_valid:
  - sum[i] = p[i] ^ c[i]
  - cout = c8
  - ovf = c8 ^ c7
  - zero
  - neg
- Stage 2 hold: when stalled (s2_valid & !out_ready), all out_* values hold stable.
- Latency: 2 cycles from input transfer to out_valid with no stalls. Throughput is 1 op/cycle.
- Full pipeline with out_ready=0: both stages are held and in_ready=0. When out_ready rises, in_ready=1 in the same cycle and stage 1 shifts forward.
- Simultaneous output and input transfer with both stages full: the output drains, stage 1 moves to stage 2, and the new input loads stage 1. No bubble and no loss.
- in_a/in_b/in_cin/in_sub are don't-care when in_valid=0.
- op_count increments by 1 on each output transfer and saturates at 2^COUNT_W-1 (no wrap).
- Arithmetic is modulo 256. cout/ovf follow standard two's-complement rules.

Test Plan:
- Add without stall: in 0x3C+0x45, cin=0 -> 2 cycles later sum=0x81, cout=0, ovf=1, neg=1, zero=0.
- Full carry chain: in 0xFF+0x00, cin=1 -> sum=0x00, cout=1, zero=1, ovf=0. This exercises the 5-input c4 term and the GP0 path into c8.
- Subtract: 0x10-0x20 (sub=1) -> sum=0xF0, cout=0, neg=1, ovf=0. Then 0x80-0x01 -> sum=0x7F, cout=1, ovf=1.
- Backpressure: stream 4 ops back-to-back with out_ready=0 from cycle 2 -> in_ready falls after 2 accepted, outputs hold stable. Release out_ready -> all 4 results emerge in order with no loss or duplicates, and op_count=4.
- Reset mid-flight: accept 2 ops, assert rst for 1 cycle -> out_valid=0, op_count=0, in_ready=1 next cycle, no stale result emerges.
- Counter saturation with COUNT_W=4: complete 20 ops -> op_count stops at 15.
